// File: rtl/control_unit.sv
// Instruction decoder and run/halt sequencer for the 16-bit load/store core.
// Decode is purely combinational; only run state, latched ALU flags and EXEC history are stored.
//
// state    | meaning
// ST_HALT  | stopped: no writes, PC held via pcl=1 with im=-1
// ST_RUN   | executing one instruction per clock
module control_unit (
   input  logic        clock,
   input  logic        RESET,
   input  logic        EXEC,
   input  logic [15:0] command,
   input  logic [3:0]  SZVC,
   output logic        rs,
   output logic [15:0] im,
   output logic        ar,
   output logic        br,
   output logic [3:0]  s_alu,
   output logic        in,
   output logic [2:0]  wAdr,
   output logic        adr,
   output logic        w,
   output logic        pcl
);

   typedef enum logic {
      ST_HALT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  flags_q;
   logic        exec_q;

   logic [1:0]  fmt;
   logic [3:0]  op3;
   logic [2:0]  op2;
   logic [2:0]  cond;
   logic [15:0] sext8;
   logic [15:0] zext4;

   logic        flag_s, flag_z, flag_v;
   logic        unused_carry;
   logic        taken;
   logic        is_hlt;
   logic        flag_en;
   logic        exec_rise;
   logic        running;

   logic [15:0] dec_im;
   logic        dec_w;
   logic        dec_adr;
   logic        dec_pcl;

   assign fmt   = command[15:14];
   assign op3   = command[7:4];
   assign op2   = command[13:11];
   assign cond  = command[10:8];
   assign sext8 = {{8{command[7]}}, command[7:0]};
   assign zext4 = {12'h000, command[3:0]};

   assign flag_s       = flags_q[3];
   assign flag_z       = flags_q[2];
   assign flag_v       = flags_q[1];
   assign unused_carry = flags_q[0];

   assign running   = (state_q == ST_RUN);
   assign exec_rise = EXEC & ~exec_q;
   assign is_hlt    = (fmt == 2'b11) && (op3 == 4'hF);
   assign flag_en   = running && (fmt == 2'b11) && (op3 <= 4'd11);

   always_comb begin
      taken = 1'b0;
      case (cond)
         3'b000:  taken = flag_z;
         3'b001:  taken = flag_s ^ flag_v;
         3'b010:  taken = flag_z | (flag_s ^ flag_v);
         3'b011:  taken = ~flag_z;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      s_alu   = 4'b0000;
      rs      = 1'b0;
      ar      = 1'b0;
      br      = 1'b0;
      in      = 1'b0;
      wAdr    = command[10:8];
      dec_im  = 16'h0000;
      dec_w   = 1'b0;
      dec_adr = 1'b0;
      dec_pcl = 1'b0;
      case (fmt)
         2'b11: begin
            if (op3 <= 4'd6) begin
               s_alu = op3;
               ar    = 1'b1;
               dec_w = (op3 != 4'd5);
            end else if (op3[3:2] == 2'b10) begin
               s_alu  = op3;
               ar     = 1'b1;
               br     = 1'b1;
               dec_im = zext4;
               dec_w  = 1'b1;
            end else begin
               case (op3)
                  4'hC: begin
                     s_alu = 4'b0110;
                     in    = 1'b1;
                     dec_w = 1'b1;
                  end
                  4'hD: begin
                     s_alu   = 4'b0110;
                     in      = 1'b1;
                     dec_adr = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         2'b00: begin
            ar     = 1'b1;
            br     = 1'b1;
            rs     = 1'b1;
            dec_im = sext8;
            dec_w  = 1'b1;
            wAdr   = command[13:11];
         end
         2'b01: begin
            ar      = 1'b1;
            br      = 1'b1;
            dec_im  = sext8;
            dec_adr = 1'b1;
         end
         default: begin
            case (op2)
               3'b000: begin
                  s_alu  = 4'b0110;
                  br     = 1'b1;
                  dec_im = sext8;
                  dec_w  = 1'b1;
               end
               3'b100: begin
                  br      = 1'b1;
                  dec_im  = sext8;
                  dec_pcl = 1'b1;
               end
               3'b111: begin
                  br      = 1'b1;
                  dec_im  = sext8;
                  dec_pcl = taken;
               end
               default: ;
            endcase
         end
      endcase
   end

   // Halted: PC+1+(-1) keeps the PC parked on the current instruction.
   always_comb begin
      if (running) begin
         im  = dec_im;
         w   = dec_w;
         adr = dec_adr;
         pcl = dec_pcl;
      end else begin
         im  = 16'hFFFF;
         w   = 1'b0;
         adr = 1'b0;
         pcl = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALT: if (exec_rise) state_d = ST_RUN;
         ST_RUN:  if (exec_rise || is_hlt) state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clock or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_HALT;
         flags_q <= 4'b0000;
         exec_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exec_q  <= EXEC;
         if (flag_en) flags_q <= SZVC;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step pushes its expected decode to a scoreboard,
// which is popped and compared at the following falling edge.
module tb_control_unit;

   logic        clock;
   logic        RESET;
   logic        EXEC;
   logic [15:0] command;
   logic [3:0]  SZVC;
   logic        rs;
   logic [15:0] im;
   logic        ar;
   logic        br;
   logic [3:0]  s_alu;
   logic        io_in;
   logic [2:0]  wAdr;
   logic        adr;
   logic        w;
   logic        pcl;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [3:0]  s_alu;
      logic        rs;
      logic        ar;
      logic        br;
      logic        in;
      logic [2:0]  wAdr;
      logic [15:0] im;
      logic        adr;
      logic        w;
      logic        pcl;
   } exp_t;

   exp_t sb[$];

   control_unit dut (
      .clock  (clock),
      .RESET  (RESET),
      .EXEC   (EXEC),
      .command(command),
      .SZVC   (SZVC),
      .rs     (rs),
      .im     (im),
      .ar     (ar),
      .br     (br),
      .s_alu  (s_alu),
      .in     (io_in),
      .wAdr   (wAdr),
      .adr    (adr),
      .w      (w),
      .pcl    (pcl)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t ex(input string tag, input logic [3:0] s, input logic r,
                               input logic a, input logic b, input logic i,
                               input logic [2:0] wa, input logic [15:0] imv,
                               input logic ad, input logic wv, input logic p);
      exp_t e;
      e.tag = tag; e.s_alu = s; e.rs = r; e.ar = a; e.br = b; e.in = i;
      e.wAdr = wa; e.im = imv; e.adr = ad; e.w = wv; e.pcl = p;
      return e;
   endfunction

   function automatic exp_t hx(input exp_t e);
      exp_t h;
      h = e;
      h.tag = {e.tag, "_halted"};
      h.im = 16'hFFFF; h.w = 1'b0; h.adr = 1'b0; h.pcl = 1'b1;
      return h;
   endfunction

   task automatic chk(input string tag, input string name, input logic [15:0] obs,
                      input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s %s observed=%h expected=%h", tag, name, obs, expv);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "s_alu", {12'h000, s_alu}, {12'h000, e.s_alu});
      chk(e.tag, "rs",    {15'h0000, rs},   {15'h0000, e.rs});
      chk(e.tag, "ar",    {15'h0000, ar},   {15'h0000, e.ar});
      chk(e.tag, "br",    {15'h0000, br},   {15'h0000, e.br});
      chk(e.tag, "in",    {15'h0000, io_in}, {15'h0000, e.in});
      chk(e.tag, "wAdr",  {13'h0000, wAdr}, {13'h0000, e.wAdr});
      chk(e.tag, "im",    im,               e.im);
      chk(e.tag, "adr",   {15'h0000, adr},  {15'h0000, e.adr});
      chk(e.tag, "w",     {15'h0000, w},    {15'h0000, e.w});
      chk(e.tag, "pcl",   {15'h0000, pcl},  {15'h0000, e.pcl});
   endtask

   task automatic step(input logic [15:0] cmd, input logic [3:0] f, input logic ex_i,
                       input exp_t e);
      command = cmd;
      SZVC    = f;
      EXEC    = ex_i;
      sb.push_back(e);
      @(negedge clock);
      compare_out();
      @(posedge clock);
      #1;
   endtask

   initial begin
      exp_t e_add, e_and, e_cmp, e_hlt;
      //           tag     s_alu  rs ar br in wAdr   im        adr w  pcl
      e_add = ex("add",  4'h0, 0, 1, 0, 0, 3'd5, 16'h0000, 0, 1, 0);
      e_and = ex("and",  4'h2, 0, 1, 0, 0, 3'd5, 16'h0000, 0, 1, 0);
      e_cmp = ex("cmp",  4'h5, 0, 1, 0, 0, 3'd2, 16'h0000, 0, 0, 0);
      e_hlt = ex("hlt",  4'h0, 0, 0, 0, 0, 3'd6, 16'h0000, 0, 0, 0);

      RESET = 1'b1; EXEC = 1'b0; command = 16'hFD0F; SZVC = 4'h0;
      step(16'hFD0F, 4'h0, 1'b0, hx(e_add));
      RESET = 1'b0;
      step(16'hFD0F, 4'h0, 1'b0, hx(e_add));
      step(16'hFD0F, 4'h0, 1'b1, hx(e_add));
      step(16'hFD0F, 4'h0, 1'b1, e_add);
      step(16'hFD20, 4'h0, 1'b0, e_and);
      step(16'h3D00, 4'h0, 1'b0, ex("ld", 4'h0, 1, 1, 1, 0, 3'd7, 16'h0000, 0, 1, 0));
      step(16'h4AFE, 4'h0, 1'b0, ex("st", 4'h0, 0, 1, 1, 0, 3'd2, 16'hFFFE, 1, 0, 0));
      step(16'h837F, 4'h0, 1'b0, ex("li_pos", 4'h6, 0, 0, 1, 0, 3'd3, 16'h007F, 0, 1, 0));
      step(16'h8380, 4'h0, 1'b0, ex("li_neg", 4'h6, 0, 0, 1, 0, 3'd3, 16'hFF80, 0, 1, 0));
      step(16'hC28F, 4'h0, 1'b0, ex("sll", 4'h8, 0, 1, 1, 0, 3'd2, 16'h000F, 0, 1, 0));
      step(16'hCA50, 4'b0100, 1'b0, e_cmp);
      step(16'hB804, 4'h0, 1'b0, ex("be_t", 4'h0, 0, 0, 1, 0, 3'd0, 16'h0004, 0, 0, 1));
      step(16'hBB04, 4'b1011, 1'b0, ex("bne_nt", 4'h0, 0, 0, 1, 0, 3'd3, 16'h0004, 0, 0, 0));
      step(16'hB904, 4'b1000, 1'b0, ex("blt_nt", 4'h0, 0, 0, 1, 0, 3'd1, 16'h0004, 0, 0, 0));
      step(16'hBA04, 4'h0, 1'b0, ex("ble_t", 4'h0, 0, 0, 1, 0, 3'd2, 16'h0004, 0, 0, 1));
      step(16'hCA10, 4'b1000, 1'b0, ex("sub", 4'h1, 0, 1, 0, 0, 3'd2, 16'h0000, 0, 1, 0));
      step(16'hB9FE, 4'b0100, 1'b0, ex("blt_t", 4'h0, 0, 0, 1, 0, 3'd1, 16'hFFFE, 0, 0, 1));
      step(16'hB804, 4'b0100, 1'b0, ex("be_nt", 4'h0, 0, 0, 1, 0, 3'd0, 16'h0004, 0, 0, 0));
      step(16'hBC04, 4'h0, 1'b0, ex("bcc_other", 4'h0, 0, 0, 1, 0, 3'd4, 16'h0004, 0, 0, 0));
      step(16'hA010, 4'h0, 1'b0, ex("b", 4'h0, 0, 0, 1, 0, 3'd0, 16'h0010, 0, 0, 1));
      step(16'h9501, 4'h0, 1'b0, ex("unlisted", 4'h0, 0, 0, 0, 0, 3'd5, 16'h0000, 0, 0, 0));
      step(16'hC4C0, 4'h0, 1'b0, ex("in", 4'h6, 0, 0, 0, 1, 3'd4, 16'h0000, 0, 1, 0));
      step(16'hD8D0, 4'h0, 1'b0, ex("out", 4'h6, 0, 0, 0, 1, 3'd0, 16'h0000, 1, 0, 0));
      step(16'hD370, 4'h0, 1'b0, ex("nop7", 4'h0, 0, 0, 0, 0, 3'd3, 16'h0000, 0, 0, 0));
      step(16'hD3E0, 4'h0, 1'b0, ex("nopE", 4'h0, 0, 0, 0, 0, 3'd3, 16'h0000, 0, 0, 0));
      step(16'hC6F0, 4'h0, 1'b0, e_hlt);
      step(16'hFD0F, 4'h0, 1'b0, hx(e_add));
      step(16'hFD0F, 4'h0, 1'b1, hx(e_add));
      step(16'hFD0F, 4'h0, 1'b1, e_add);
      step(16'hFD20, 4'h0, 1'b0, e_and);
      // HLT and an EXEC rise on the same edge must still leave the core halted
      step(16'hC6F0, 4'h0, 1'b1, e_hlt);
      step(16'hFD20, 4'h0, 1'b1, hx(e_and));
      step(16'hFD20, 4'h0, 1'b0, hx(e_and));
      step(16'hFD20, 4'h0, 1'b1, hx(e_and));
      step(16'hFD20, 4'h0, 1'b0, e_and);
      step(16'hFD20, 4'h0, 1'b1, e_and);
      step(16'hFD20, 4'h0, 1'b1, hx(e_and));
      step(16'hFD20, 4'h0, 1'b0, hx(e_and));
      step(16'hFD20, 4'h0, 1'b1, hx(e_and));
      step(16'hCA50, 4'b0100, 1'b0, e_cmp);
      step(16'hFD20, 4'h0, 1'b0, e_and);
      #2;
      RESET = 1'b1;
      step(16'hFD20, 4'h0, 1'b0, hx(e_and));
      step(16'hFD0F, 4'b0100, 1'b0, hx(e_add));
      RESET = 1'b0;
      step(16'hFD0F, 4'b0100, 1'b0, hx(e_add));
      step(16'hFD0F, 4'b0100, 1'b1, hx(e_add));
      step(16'hB804, 4'b0100, 1'b0, ex("be_after_rst", 4'h0, 0, 0, 1, 0, 3'd0, 16'h0004, 0, 0, 0));
      step(16'hBB04, 4'h0, 1'b0, ex("bne_after_rst", 4'h0, 0, 0, 1, 0, 3'd3, 16'h0004, 0, 0, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

- Instruction decoder and sequencing controller for the 16-bit load/store processor.
- Decodes the current instruction word into datapath controls: ALU op, operand selects, immediate, register write, memory/IO strobe and PC load.
- Latches ALU condition flags and keeps a run/halt state.
- The datapath reads registers directly from command[13:11] and command[10:8].
- The datapath's PC increments every cycle unless pcl loads PC+1+im.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- EXEC  in  1  run/stop request; each 0→1 transition sampled at clock toggles run state
- command  in  16  current instruction word
- SZVC  in  4  ALU flags of current result: [3]=S, [2]=Z, [1]=V, [0]=C
- rs  out  1  writeback source: 1 = memory read data, 0 = ALU result
- im  out  16  immediate to datapath
- ar  out  1  ALU A select: 1 = reg[command[10:8]], 0 = constant 0
- br  out  1  ALU B select: 1 = im, 0 = reg[command[13:11]]
- s_alu  out  4  ALU operation code
- in  out  1  IO select: ALU B from external input (IN); with adr, routes write strobe to output port
- wAdr  out  3  register write address
- adr  out  1  write strobe: in=0 → data-memory write, in=1 → output-port write
- w  out  1  register-file write enable
- pcl  out  1  PC load (PC ← PC+1+im)

## Operation
- Formats:
  - 11 = arithmetic: [13:11] Rs, [10:8] Rd, [7:4] op3, [3:0] d.
  - 00 = LD Ra,d(Rb) and 01 = ST Ra,d(Rb): [13:11] Ra, [10:8] Rb, [7:0] d.
  - 10 = [13:11] op2, [10:8] Rb/cond, [7:0] d.
- sext(d8) = 8-bit d sign-extended to 16 bits; zext(d4) = 4-bit d zero-extended.
- Arithmetic op3 0000–0110 (ADD, SUB, AND, OR, XOR, CMP, MOV):
  - s_alu=op3, ar=1, br=0, im=0, rs=0, wAdr=Rd.
  - w=1 except CMP (0101).
- Shifts op3 1000–1011 (SLL, SLR, SRL, SRA): s_alu=op3, ar=1, br=1, im=zext(d4), w=1, wAdr=Rd.
- IN (1100): s_alu=0110, in=1, w=1, wAdr=Rd.
- OUT (1101): s_alu=0110, br=0, in=1, adr=1, w=0.
- HLT (1111): s_alu=0000, w=0, adr=0, pcl=0; stops run at next edge.
- op3 0111 and 1110: NOP.
- LD: s_alu=0000, ar=1, br=1, im=sext(d8), rs=1, w=1, wAdr=Ra.
- ST: s_alu=0000, ar=1, br=1, im=sext(d8), adr=1, in=0, w=0.
- LI (op2 000): s_alu=0110, ar=0, br=1, im=sext(d8), w=1, wAdr=command[10:8].
- B (op2 100): pcl=1, im=sext(d8).
- Conditional branch (op2 111), pcl taken per cond field (command[10:8]) from latched flags:
  - 000 BE: Z.
  - 001 BLT: S^V.
  - 010 BLE: Z|(S^V).
  - 011 BNE: !Z.
  - Other cond values: not taken.
- Branches: s_alu=0000, ar=0, br=1, w=0, adr=0.
- NOP / unlisted encodings: all outputs 0.
  - Exception: wAdr=command[10:8] whenever not otherwise defined.
- s_alu, rs, ar, br, in, wAdr are pure combinational functions of command; they never depend on state.
- Flag register latches SZVC on posedge when running and op is arithmetic/shift (op3 0000–1011 in format 11).

## Timing
- All outputs are combinational from command, flag register and run state.
- State updates occur on posedge clock.
- RESET high, asynchronous: run=0, flags=0000, EXEC history=0.
- While halted (including during and after reset): w=0, adr=0, pcl=1, im=16'hFFFF, so PC holds.
  - Other outputs keep their normal decode.
- EXEC rise detected from the registered previous EXEC value.
  - Halted + rise → running from the next cycle.
  - Running + rise → halted.
- HLT while running: halted after that edge.
  - PC advances past the HLT (pcl=0 that cycle), so resume continues at the next instruction.
- HLT and EXEC rise on the same edge: halted.
- Flags are not updated while halted.
- A branch uses flags latched by earlier instructions, never same-cycle SZVC.

## Test plan
- RESET=1, then 0 with EXEC=0 → w=0, adr=0, pcl=1, im=FFFF; command FD0F still gives s_alu=0000.
- Running, command FD0F (ADD Rs=7 Rd=5) → s_alu=0000, ar=1, br=0, rs=0, w=1, wAdr=101, pcl=0.
- Running, command FD20 (AND) → s_alu=0010, w=1, wAdr=101; then command 3D00 (LD R7,0(R5)) → s_alu=0000, rs=1, br=1, im=0000, w=1, wAdr=111.
- Running, ST with d=8'hFE → im=FFFE, adr=1, in=0, w=0; LI d=8'h7F → im=007F, s_alu=0110, ar=0.
- Running, CMP with SZVC=0100 latched, then BE d=8'h04 → pcl=1, im=0004; then BNE → pcl=0.
- Running, HLT → pcl=0 that cycle, then halted outputs; EXEC 0→1 → running resumes; RESET mid-run → halted immediately.
